// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: mode and state encodings and per-mode line/frame timing.
// The field layout is kept wide so the controller can be built with any coordinate width.
package vga_timing_pkg;

    localparam int REZ_MAX_WIDTH_DEFAULT = 11;
    localparam int PULSE_WIDTH_DEFAULT   = 8;

    typedef enum logic [1:0] {
        MODE_640X480  = 2'd0,
        MODE_800X600  = 2'd1,
        MODE_1024X768 = 2'd2,
        MODE_INVALID  = 2'd3
    } vga_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } vga_state_e;

    typedef struct packed {
        logic [15:0] total;
        logic [15:0] sync;
        logic [15:0] back_porch;
        logic [15:0] active;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } mode_timing_t;

    function automatic axis_timing_t axis_timing(input int total, input int sync,
                                                 input int back_porch, input int active);
        axis_timing_t t;
        t.total      = 16'(total);
        t.sync       = 16'(sync);
        t.back_porch = 16'(back_porch);
        t.active     = 16'(active);
        return t;
    endfunction

    // The invalid encoding never reaches the active mode register; it falls back to 640x480.
    function automatic mode_timing_t mode_timing(input vga_mode_e mode);
        mode_timing_t t;
        case (mode)
            MODE_800X600: begin
                t.h = axis_timing(1056, 128, 88, 800);
                t.v = axis_timing(628, 4, 23, 600);
            end
            MODE_1024X768: begin
                t.h = axis_timing(1344, 136, 160, 1024);
                t.v = axis_timing(806, 6, 29, 768);
            end
            default: begin
                t.h = axis_timing(800, 96, 48, 640);
                t.v = axis_timing(525, 2, 33, 480);
            end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/vga_timing_controller_axis_counter.sv
// One axis (horizontal or vertical) of the raster: wrapping position counter plus
// sync and active-region decode of that registered position.
module vga_axis_counter #(
    parameter int W  = 11,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          en,
    input  logic          clr,
    input  logic [W-1:0]  total,
    input  logic [PW-1:0] sync_len,
    input  logic [W-1:0]  act_start,
    input  logic [W-1:0]  act_len,
    output logic [W-1:0]  cnt,
    output logic [W-1:0]  coord,
    output logic          wrap,
    output logic          sync_n,
    output logic          active
);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;
    logic [W-1:0] act_end;

    assign wrap    = en && (cnt_reg == (total - W'(1)));
    assign act_end = act_start + act_len;

    // Clear wins over advance so leaving the raster always restarts at the origin.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = wrap ? '0 : cnt_reg + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt    = cnt_reg;
    assign sync_n = (32'(cnt_reg) >= 32'(sync_len));
    assign active = (cnt_reg >= act_start) && (cnt_reg < act_end);
    assign coord  = active ? (cnt_reg - act_start) : '0;

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing generator with three selectable modes; mode changes are queued and
// applied only at a frame boundary (or when restarting from idle) so no frame is torn.
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int REZ_MAX_WIDTH = REZ_MAX_WIDTH_DEFAULT,
    parameter int PULSE_WIDTH   = PULSE_WIDTH_DEFAULT
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     En,
    input  logic                     Pix_en,
    input  logic                     Mode_req,
    input  logic [1:0]               Mode_sel,
    output logic                     Mode_ack,
    output logic                     Mode_err,
    output logic                     Busy,
    output logic                     Hsync,
    output logic                     Vsync,
    output logic                     De,
    output logic [REZ_MAX_WIDTH-1:0] Pixel_x,
    output logic [REZ_MAX_WIDTH-1:0] Pixel_y,
    output logic                     Frame_start
);

    vga_state_e   state_reg;
    vga_state_e   state_next;
    vga_mode_e    mode_reg;
    vga_mode_e    pend_mode_reg;
    logic         busy_reg;
    logic         ack_reg;
    logic         err_reg;
    logic         cnt_clr;
    logic         apply_pend;
    logic         running;
    logic         req_valid;
    logic         req_invalid;
    mode_timing_t timing;

    logic                     h_en, h_wrap, h_sync_n, h_act;
    logic                     v_en, v_wrap, v_sync_n, v_act;
    logic [REZ_MAX_WIDTH-1:0] h_cnt, h_coord, v_cnt, v_coord;

    assign timing      = mode_timing(mode_reg);
    assign running     = (state_reg == ST_RUN);
    assign req_invalid = Mode_req && (Mode_sel == MODE_INVALID);
    assign req_valid   = Mode_req && (Mode_sel != MODE_INVALID);

    assign h_en = running && Pix_en;
    assign v_en = h_en && h_wrap;

    vga_axis_counter #(.W(REZ_MAX_WIDTH), .PW(PULSE_WIDTH)) u_h_axis (
        .clk       (Clk),
        .srst      (Rst),
        .en        (h_en),
        .clr       (cnt_clr),
        .total     (REZ_MAX_WIDTH'(timing.h.total)),
        .sync_len  (PULSE_WIDTH'(timing.h.sync)),
        .act_start (REZ_MAX_WIDTH'(timing.h.sync + timing.h.back_porch)),
        .act_len   (REZ_MAX_WIDTH'(timing.h.active)),
        .cnt       (h_cnt),
        .coord     (h_coord),
        .wrap      (h_wrap),
        .sync_n    (h_sync_n),
        .active    (h_act)
    );

    vga_axis_counter #(.W(REZ_MAX_WIDTH), .PW(PULSE_WIDTH)) u_v_axis (
        .clk       (Clk),
        .srst      (Rst),
        .en        (v_en),
        .clr       (cnt_clr),
        .total     (REZ_MAX_WIDTH'(timing.v.total)),
        .sync_len  (PULSE_WIDTH'(timing.v.sync)),
        .act_start (REZ_MAX_WIDTH'(timing.v.sync + timing.v.back_porch)),
        .act_len   (REZ_MAX_WIDTH'(timing.v.active)),
        .cnt       (v_cnt),
        .coord     (v_coord),
        .wrap      (v_wrap),
        .sync_n    (v_sync_n),
        .active    (v_act)
    );

    // v_wrap already implies the last pixel of the frame was consumed this cycle.
    always_comb begin
        state_next = state_reg;
        cnt_clr    = 1'b0;
        apply_pend = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (En) begin
                    state_next = ST_RUN;
                    apply_pend = busy_reg;
                end
            end
            ST_RUN: begin
                if (!En) begin
                    state_next = ST_IDLE;
                    cnt_clr    = 1'b1;
                end else if (v_wrap && busy_reg) begin
                    state_next = ST_SWITCH;
                    cnt_clr    = 1'b1;
                    apply_pend = 1'b1;
                end
            end
            ST_SWITCH: begin
                cnt_clr    = 1'b1;
                state_next = ST_RUN;
            end
            default: begin
                cnt_clr    = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A request arriving on the same edge as an apply becomes the next pending change.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            mode_reg      <= MODE_640X480;
            pend_mode_reg <= MODE_640X480;
            busy_reg      <= 1'b0;
            ack_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            ack_reg <= apply_pend;
            err_reg <= req_invalid;
            if (apply_pend) begin
                mode_reg <= pend_mode_reg;
                busy_reg <= 1'b0;
            end
            if (req_valid) begin
                pend_mode_reg <= vga_mode_e'(Mode_sel);
                busy_reg      <= 1'b1;
            end
        end
    end

    assign Hsync       = running ? h_sync_n : 1'b1;
    assign Vsync       = running ? v_sync_n : 1'b1;
    assign De          = running && h_act && v_act;
    assign Pixel_x     = De ? h_coord : '0;
    assign Pixel_y     = De ? v_coord : '0;
    assign Frame_start = running && Pix_en && (h_cnt == '0) && (v_cnt == '0);
    assign Mode_ack    = ack_reg;
    assign Mode_err    = err_reg;
    assign Busy        = busy_reg;

endmodule
